// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths and entry type for the fetch queue
package fetch_queue_pkg;
  localparam int INSN_LEN = 32;
  localparam int ADDR_LEN = 32;
  localparam logic [ADDR_LEN-1:0] INSN_BYTES = ADDR_LEN'(4);
  typedef struct packed {
    logic [INSN_LEN-1:0] inst;
    logic [ADDR_LEN-1:0] pc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side signals of the fetch queue
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
);
  logic                    flush;
  logic                    enq_valid;
  logic                    enq_inst2_valid;
  logic [INSN_LEN-1:0]     enq_inst1;
  logic [INSN_LEN-1:0]     enq_inst2;
  logic [ADDR_LEN-1:0]     enq_pc;
  logic                    enq_ready;
  logic                    deq_valid1;
  logic                    deq_valid2;
  logic [INSN_LEN-1:0]     deq_inst1;
  logic [INSN_LEN-1:0]     deq_inst2;
  logic [ADDR_LEN-1:0]     deq_pc1;
  logic [ADDR_LEN-1:0]     deq_pc2;
  logic                    deq_ready;
  logic [$clog2(DEPTH):0]  count;
  modport slave (
    input  flush, enq_valid, enq_inst2_valid, enq_inst1, enq_inst2, enq_pc, deq_ready,
    output enq_ready, deq_valid1, deq_valid2, deq_inst1, deq_inst2, deq_pc1, deq_pc2, count
  );
  modport master (
    output flush, enq_valid, enq_inst2_valid, enq_inst1, enq_inst2, enq_pc, deq_ready,
    input  enq_ready, deq_valid1, deq_valid2, deq_inst1, deq_inst2, deq_pc1, deq_pc2, count
  );
endinterface

// File: rtl/fetch_queue_ram.sv
// fetch_queue_ram: entry storage with two write ports and two async read ports
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we1,
  input  logic          we2,
  input  logic [PW-1:0] wa1,
  input  logic [PW-1:0] wa2,
  input  fq_entry_t     wd1,
  input  fq_entry_t     wd2,
  input  logic [PW-1:0] ra1,
  input  logic [PW-1:0] ra2,
  output fq_entry_t     rd1,
  output fq_entry_t     rd2
);
  fq_entry_t mem [DEPTH];
  // write both bundle slots; the two addresses are always distinct
  always_ff @(posedge clk) begin
    if (we1) mem[wa1] <= wd1;
    if (we2) mem[wa2] <= wd2;
  end
  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: two-wide FWFT instruction buffer between fetch and decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         reset,
  fetch_queue_if.slave fq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic [1:0]    nenq, ndeq;
  logic          v1, v2, enq_fire, we1, we2;
  fq_entry_t     rd1, rd2;
  assign v1 = cnt != '0;
  assign v2 = cnt >= CW'(2);
  assign fq.enq_ready = cnt <= CW'(DEPTH - 2);
  assign enq_fire = fq.enq_valid & fq.enq_ready;
  assign nenq = enq_fire ? (fq.enq_inst2_valid ? 2'd2 : 2'd1) : 2'd0;
  assign ndeq = fq.deq_ready ? {1'b0, v1} + {1'b0, v2} : 2'd0;
  assign we1 = enq_fire & ~fq.flush & ~reset;
  assign we2 = we1 & fq.enq_inst2_valid;
  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk (clk),
    .we1 (we1),
    .we2 (we2),
    .wa1 (tail),
    .wa2 (tail + PW'(1)),
    .wd1 ('{inst: fq.enq_inst1, pc: fq.enq_pc}),
    .wd2 ('{inst: fq.enq_inst2, pc: fq.enq_pc + INSN_BYTES}),
    .ra1 (head),
    .ra2 (head + PW'(1)),
    .rd1 (rd1),
    .rd2 (rd2)
  );
  // pointers and occupancy; reset and flush both empty the queue and drop same-cycle traffic
  always_ff @(posedge clk) begin
    if (reset || fq.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(ndeq);
      tail <= tail + PW'(nenq);
      cnt  <= cnt + CW'(nenq) - CW'(ndeq);
    end
  end
  assign fq.count      = cnt;
  assign fq.deq_valid1 = v1;
  assign fq.deq_valid2 = v2;
  assign fq.deq_inst1  = v1 ? rd1.inst : '0;
  assign fq.deq_pc1    = v1 ? rd1.pc : '0;
  assign fq.deq_inst2  = v2 ? rd2.inst : '0;
  assign fq.deq_pc2    = v2 ? rd2.pc : '0;
endmodule
